// File: rtl/imm_gen_if.sv
// Handshake bundle between decode, the immediate stage and ID/EX.
// The stage sits on the slave modport; the upstream/downstream driver uses master.
interface imm_gen_if #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 32
);
  logic [31:0]           instr;
  logic [2:0]            ImmSrc;
  logic [TAG_WIDTH-1:0]  in_tag;
  logic                  in_valid;
  logic                  in_ready;
  logic                  flush;
  logic [DATA_WIDTH-1:0] ExtImm;
  logic [TAG_WIDTH-1:0]  out_tag;
  logic                  ImmIllegal;
  logic                  out_valid;
  logic                  out_ready;

  modport slave (
    input  instr, ImmSrc, in_tag, in_valid, flush, out_ready,
    output in_ready, ExtImm, out_tag, ImmIllegal, out_valid
  );

  modport master (
    output instr, ImmSrc, in_tag, in_valid, flush, out_ready,
    input  in_ready, ExtImm, out_tag, ImmIllegal, out_valid
  );
endinterface

// File: rtl/imm_gen_stage.sv
// RISC-V immediate extension feeding a 2-entry in-order skid buffer with
// valid/ready handshake and flush; result and tag are held until consumed.
module imm_gen_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 32
) (
  input  logic      clk,
  input  logic      rst,
  imm_gen_if.slave  bus
);

  function automatic logic signed [DATA_WIDTH-1:0] ext_imm(
    input logic [31:0] ins,
    input logic [2:0]  src
  );
    logic signed [31:0] v32;
    v32 = '0;
    case (src)
      3'b000: v32 = {{20{ins[31]}}, ins[31:20]};
      3'b001: v32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      3'b010: v32 = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
      3'b011: v32 = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
      3'b100: v32 = {ins[31:12], 12'd0};
      3'b101: v32 = (DATA_WIDTH == 64) ? {26'd0, ins[25:20]} : {27'd0, ins[24:20]};
      3'b110: v32 = {27'd0, ins[19:15]};
      default: v32 = '0;
    endcase
    // Signed widening gives the sign copies above bit 31 on RV64
    return DATA_WIDTH'(v32);
  endfunction

  logic [1:0]                   count_q, count_d;
  logic                         head_q, head_d;
  logic                         tail_q, tail_d;
  logic signed [DATA_WIDTH-1:0] imm_q [2];
  logic signed [DATA_WIDTH-1:0] imm_d [2];
  logic [TAG_WIDTH-1:0]         tag_q [2];
  logic [TAG_WIDTH-1:0]         tag_d [2];
  logic [1:0]                   ill_q, ill_d;
  logic                         push, pop;
  logic                         in_ready, out_valid;

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);

  always_comb begin
    push    = bus.in_valid && in_ready && !bus.flush;
    pop     = out_valid && bus.out_ready && !bus.flush;
    count_d = count_q;
    head_d  = head_q ^ pop;
    tail_d  = tail_q ^ push;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    if (bus.flush) begin
      count_d = '0;
      head_d  = 1'b0;
      tail_d  = 1'b0;
    end
  end

  always_comb begin
    imm_d = imm_q;
    tag_d = tag_q;
    ill_d = ill_q;
    if (push) begin
      imm_d[tail_q] = ext_imm(bus.instr, bus.ImmSrc);
      tag_d[tail_q] = bus.in_tag;
      ill_d[tail_q] = (bus.ImmSrc == 3'b111);
    end
  end

  // Control state: reset asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  // Entry storage: no reset, outputs are masked while empty
  always_ff @(posedge clk) begin
    imm_q <= imm_d;
    tag_q <= tag_d;
    ill_q <= ill_d;
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid;
  assign bus.ExtImm     = out_valid ? imm_q[head_q] : '0;
  assign bus.out_tag    = out_valid ? tag_q[head_q] : '0;
  assign bus.ImmIllegal = out_valid ? ill_q[head_q] : 1'b0;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: RV32 and RV64 instances driven in lockstep and
// compared against an arithmetic immediate model plus a queue-based buffer model.
module tb_imm_gen_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = '0;
  logic [2:0]  imm_src = '0;
  logic [31:0] in_tag = '0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        flush = 1'b0;

  int total = 0;
  int bad = 0;

  imm_gen_if #(.DATA_WIDTH(32), .TAG_WIDTH(32)) if32 ();
  imm_gen_if #(.DATA_WIDTH(64), .TAG_WIDTH(32)) if64 ();

  assign if32.instr = instr;   assign if64.instr = instr;
  assign if32.ImmSrc = imm_src; assign if64.ImmSrc = imm_src;
  assign if32.in_tag = in_tag;  assign if64.in_tag = in_tag;
  assign if32.in_valid = in_valid; assign if64.in_valid = in_valid;
  assign if32.out_ready = out_ready; assign if64.out_ready = out_ready;
  assign if32.flush = flush;    assign if64.flush = flush;

  imm_gen_stage #(.DATA_WIDTH(32), .TAG_WIDTH(32)) DUT   (.clk(clk), .rst(rst), .bus(if32.slave));
  imm_gen_stage #(.DATA_WIDTH(64), .TAG_WIDTH(32)) DUT64 (.clk(clk), .rst(rst), .bus(if64.slave));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  src;
    logic [31:0] tag;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] popped[$];

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, obs, exp);
    end
  endtask

  // Immediate value from field arithmetic, folded into the requested width
  function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [2:0] src, input int w);
    longint v;
    longint u;
    logic [63:0] r;
    u = longint'(ins);
    case (src)
      3'd0: begin v = (u >> 20) & 'hFFF; if (v >= 2048) v -= 4096; end
      3'd1: begin v = (((u >> 25) & 'h7F) << 5) | ((u >> 7) & 'h1F); if (v >= 2048) v -= 4096; end
      3'd2: begin
        v = (((u >> 31) & 1) << 12) | (((u >> 7) & 1) << 11) |
            (((u >> 25) & 'h3F) << 5) | (((u >> 8) & 'hF) << 1);
        if (v >= 4096) v -= 8192;
      end
      3'd3: begin
        v = (((u >> 31) & 1) << 20) | (((u >> 12) & 'hFF) << 12) |
            (((u >> 20) & 1) << 11) | (((u >> 21) & 'h3FF) << 1);
        if (v >= longint'(1 << 20)) v -= longint'(1 << 21);
      end
      3'd4: begin v = u & 'hFFFFF000; if (v >= 64'h80000000) v -= 64'h100000000; end
      3'd5: v = (u >> 20) & ((w == 64) ? 63 : 31);
      3'd6: v = (u >> 15) & 31;
      default: v = 0;
    endcase
    r = v;
    if (w == 32) r[63:32] = '0;
    return r;
  endfunction

  task automatic check_model();
    chk("out_valid", 64'(if32.out_valid), 64'(mq.size() != 0));
    chk("in_ready", 64'(if32.in_ready), 64'(mq.size() != 2));
    chk("out_valid64", 64'(if64.out_valid), 64'(mq.size() != 0));
    chk("in_ready64", 64'(if64.in_ready), 64'(mq.size() != 2));
    if (mq.size() != 0) begin
      chk("ext32", 64'(if32.ExtImm), ref_imm(mq[0].instr, mq[0].src, 32));
      chk("ext64", if64.ExtImm, ref_imm(mq[0].instr, mq[0].src, 64));
      chk("tag", 64'(if32.out_tag), 64'(mq[0].tag));
      chk("illegal", 64'(if32.ImmIllegal), 64'(mq[0].src == 3'd7));
    end else begin
      chk("ext32_idle", 64'(if32.ExtImm), 64'd0);
      chk("ext64_idle", if64.ExtImm, 64'd0);
      chk("tag_idle", 64'(if32.out_tag), 64'd0);
      chk("illegal_idle", 64'(if32.ImmIllegal), 64'd0);
    end
  endtask

  // One clock: advance the model with the inputs present at the edge, then compare
  task automatic step();
    int was;
    ent_t e;
    if (if32.out_valid && out_ready && !flush) popped.push_back(if32.out_tag);
    was = mq.size();
    if (flush) mq.delete();
    else begin
      if (out_ready && was > 0) void'(mq.pop_front());
      if (in_valid && was < 2) begin
        e.instr = instr; e.src = imm_src; e.tag = in_tag;
        mq.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic directed(input string nm, input logic [31:0] ins, input logic [2:0] src,
                          input logic [63:0] e32, input logic [63:0] e64);
    instr = ins; imm_src = src; in_tag = in_tag + 1;
    in_valid = 1'b1; out_ready = 1'b1; flush = 1'b0;
    step();
    chk({nm, "_32"}, 64'(if32.ExtImm), e32);
    chk({nm, "_64"}, if64.ExtImm, e64);
    chk({nm, "_ill"}, 64'(if32.ImmIllegal), 64'(src == 3'd7));
    in_valid = 1'b0;
  endtask

  initial begin
    #3;
    chk("rst_out_valid", 64'(if32.out_valid), 64'd0);
    chk("rst_in_ready", 64'(if32.in_ready), 64'd1);
    chk("rst_ext", 64'(if32.ExtImm), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Format sweep
    directed("fmt_I", 32'hFFF00093, 3'd0, 64'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF);
    directed("fmt_S", 32'hFE20AE23, 3'd1, 64'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC);
    directed("fmt_B", 32'h00000463, 3'd2, 64'h00000008, 64'h0000000000000008);
    directed("fmt_J", 32'hFFDFF06F, 3'd3, 64'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC);
    directed("fmt_U", 32'h123450B7, 3'd4, 64'h12345000, 64'h0000000012345000);
    directed("fmt_U_neg", 32'h800000B7, 3'd4, 64'h80000000, 64'hFFFFFFFF80000000);
    directed("fmt_shamt", 32'h03F0D093, 3'd5, 64'h1F, 64'h3F);
    directed("fmt_zimm", 32'h0007D073, 3'd6, 64'h0F, 64'h0F);
    directed("fmt_rsvd", 32'hDEADBEEF, 3'd7, 64'h0, 64'h0);
    step();

    // Backpressure with tags 1..4
    popped.delete();
    begin
      int k = 1;
      for (int cyc = 0; cyc < 20 && popped.size() < 4; cyc++) begin
        bit acc;
        in_valid = (k <= 4);
        in_tag = k;
        instr = $urandom;
        imm_src = 3'($urandom_range(0, 7));
        out_ready = (cyc >= 5);
        acc = in_valid && (mq.size() < 2);
        step();
        if (acc) k++;
        if (cyc == 1) chk("bp_in_ready_low", 64'(if32.in_ready), 64'd0);
        if (cyc >= 2 && cyc <= 4) chk("bp_hold_tag", 64'(if32.out_tag), 64'd1);
      end
    end
    in_valid = 1'b0;
    chk("bp_count", 64'(popped.size()), 64'd4);
    for (int i = 0; i < popped.size() && i < 4; i++) chk("bp_order", 64'(popped[i]), 64'(i + 1));

    // Flush with full buffer and a same-cycle input
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_tag = 32'h11 + i; instr = $urandom; imm_src = 3'd0;
      step();
    end
    in_tag = 32'hBAD; flush = 1'b1;
    step();
    chk("flush_out_valid", 64'(if32.out_valid), 64'd0);
    chk("flush_in_ready", 64'(if32.in_ready), 64'd1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("flush_no_ghost", 64'(if32.out_valid), 64'd0);
    end

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 15) == 0);
      instr = $urandom;
      imm_src = 3'($urandom_range(0, 7));
      in_tag = $urandom;
      step();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step(); step();

    // Asynchronous reset mid-cycle with two entries held
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_tag = 32'h21 + i; instr = 32'hFFF00093; imm_src = 3'd0;
      step();
    end
    in_valid = 1'b0;
    chk("pre_rst_full", 64'(if32.in_ready), 64'd0);
    #2;
    rst = 1'b1;
    #1;
    mq.delete();
    chk("arst_out_valid", 64'(if32.out_valid), 64'd0);
    chk("arst_ext", 64'(if32.ExtImm), 64'd0);
    chk("arst_ext64", if64.ExtImm, 64'd0);
    chk("arst_in_ready", 64'(if32.in_ready), 64'd1);
    #1;
    rst = 1'b0;
    directed("post_rst_I", 32'h0010_0093, 3'd0, 64'h1, 64'h1);
    chk("post_rst_valid", 64'(if32.out_valid), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
